// File: rtl/scinstmem_loader.sv
// Instruction memory with a 1-cycle fetch port and a byte-stream image loader.
// Optional macro SCINSTMEM_MISALIGN_TRAP_EN: misaligned fetches return 0 and pulse fault.
module scinstmem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              f_req,
  input  logic [31:0]       a,
  output logic              f_ready,
  output logic [DATA_W-1:0] inst,
  output logic              f_valid,
  input  logic              ld_start,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_done,
  output logic [ADDR_W:0]   ld_words,
  output logic              ld_ovf,
  output logic              fault,
  output logic              dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int BC_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

  // Handshakes: a fetch is taken on f_req & f_ready, a byte on ld_valid & ld_ready,
  // both at the rising edge; requests seen while the matching ready is low are dropped.
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wp_q, wp_d;
  logic [BC_W-1:0]     bc_q, bc_d, bc_new;
  logic [DATA_W-1:0]   pw_q, pw_d, pw_new;
  logic [ADDR_W:0]     words_q, words_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic                f_valid_q, f_valid_d;
  logic                fault_q, fault_d;
  logic                mem_we;
  logic                byte_full;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                unused_a;

  assign unused_a = ^{a[31:ADDR_W+2], a[1:0]};

  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    bc_d      = bc_q;
    pw_d      = pw_q;
    words_d   = words_q;
    ovf_d     = ovf_q;
    inst_d    = inst_q;
    f_valid_d = 1'b0;
    fault_d   = 1'b0;
    mem_we    = 1'b0;
    pw_new    = pw_q;
    bc_new    = bc_q;
    byte_full = (bc_q == BC_W'(NB - 1));

    if (state_q == RUN && f_req) begin
      f_valid_d = 1'b1;
      inst_d    = mem[a[ADDR_W+1:2]];
`ifdef SCINSTMEM_MISALIGN_TRAP_EN
      if (a[1:0] != 2'b00) begin
        inst_d  = '0;
        fault_d = 1'b1;
      end
`endif
    end

    // ld_start wins over everything else in its cycle, including a byte offered alongside it.
    if (ld_start) begin
      state_d = LOAD;
      wp_d    = '0;
      bc_d    = '0;
      pw_d    = '0;
      words_d = '0;
      ovf_d   = 1'b0;
    end else if (state_q == LOAD) begin
      if (ld_valid) begin
        for (int i = 0; i < NB; i++) begin
          if (bc_q == BC_W'(i)) pw_new[i*8 +: 8] = ld_byte;
        end
        bc_new = byte_full ? '0 : bc_q + 1'b1;
      end
      // Unfilled bytes of pw_new are already zero, so a flush is a zero-padded write.
      mem_we = (ld_valid && byte_full) || (ld_done && bc_new != '0);
      if (mem_we) begin
        wp_d = wp_q + 1'b1;
        if (wp_q == {ADDR_W{1'b1}}) ovf_d = 1'b1;
        if (words_q != (ADDR_W+1)'(DEPTH)) words_d = words_q + 1'b1;
        bc_d = '0;
        pw_d = '0;
      end else begin
        bc_d = bc_new;
        pw_d = pw_new;
      end
      if (ld_done) state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= RUN;
      wp_q      <= '0;
      bc_q      <= '0;
      pw_q      <= '0;
      words_q   <= '0;
      ovf_q     <= 1'b0;
      inst_q    <= '0;
      f_valid_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      bc_q      <= bc_d;
      pw_q      <= pw_d;
      words_q   <= words_d;
      ovf_q     <= ovf_d;
      inst_q    <= inst_d;
      f_valid_q <= f_valid_d;
      fault_q   <= fault_d;
    end
  end

  // Storage is deliberately outside reset so an image survives clrn.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wp_q] <= pw_new;
  end

  assign f_ready   = (state_q == RUN);
  assign ld_ready  = (state_q == LOAD);
  assign inst      = inst_q;
  assign f_valid   = f_valid_q;
  assign fault     = fault_q;
  assign ld_words  = words_q;
  assign ld_ovf    = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_scinstmem_loader.sv
// Directed bench for scinstmem_loader: a default-size instance plus an ADDR_W=2
// instance sharing the same stimulus for the wrap/saturation case.
module tb_scinstmem_loader;
  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] a = '0;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_valid = 1'b0;
  logic        ld_done = 1'b0;

  logic        f_ready, f_valid, ld_ready, ld_ovf, fault, dbg_state;
  logic [31:0] inst;
  logic [8:0]  ld_words;
  logic        s_f_ready, s_f_valid, s_ld_ready, s_ld_ovf, s_fault, s_dbg_state;
  logic [31:0] s_inst;
  logic [2:0]  s_ld_words;

  int n_vec = 0;
  int n_err = 0;

  scinstmem_loader u_dut (
    .clk(clk), .clrn(clrn), .f_req(f_req), .a(a), .f_ready(f_ready), .inst(inst),
    .f_valid(f_valid), .ld_start(ld_start), .ld_byte(ld_byte), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_words(ld_words), .ld_ovf(ld_ovf),
    .fault(fault), .dbg_state(dbg_state)
  );

  scinstmem_loader #(.ADDR_W(2), .DATA_W(32)) u_small (
    .clk(clk), .clrn(clrn), .f_req(f_req), .a(a), .f_ready(s_f_ready), .inst(s_inst),
    .f_valid(s_f_valid), .ld_start(ld_start), .ld_byte(ld_byte), .ld_valid(ld_valid),
    .ld_ready(s_ld_ready), .ld_done(ld_done), .ld_words(s_ld_words), .ld_ovf(s_ld_ovf),
    .fault(s_fault), .dbg_state(s_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_valid = 1'b1; ld_byte = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic finish_load();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr);
    f_req = 1'b1; a = addr;
    tick();
    f_req = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_vec++; if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got=%h exp=0", inst); end
    n_vec++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL reset_f_valid got=%b exp=0", f_valid); end
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%b exp=0", fault); end
    n_vec++; if (ld_words !== 9'd0) begin n_err++; $display("FAIL reset_ld_words got=%0d exp=0", ld_words); end
    n_vec++; if (ld_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ld_ovf got=%b exp=0", ld_ovf); end
    n_vec++; if (f_ready !== 1'b1 || ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b%b exp=10", f_ready, ld_ready); end
    @(negedge clk);
    clrn = 1'b1;
    tick();
  endtask

  task automatic test_basic_load();
    start_load();
    n_vec++; if (f_ready !== 1'b0 || ld_ready !== 1'b1) begin n_err++; $display("FAIL load_ready got=%b%b exp=01", f_ready, ld_ready); end
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h1D); send_byte(8'h3C);
    finish_load();
    n_vec++; if (f_ready !== 1'b1) begin n_err++; $display("FAIL back_to_run got=%b exp=1", f_ready); end
    fetch(32'h0);
    n_vec++; if (inst !== 32'h3C1D0020) begin n_err++; $display("FAIL basic_inst got=%h exp=3c1d0020", inst); end
    n_vec++; if (f_valid !== 1'b1) begin n_err++; $display("FAIL basic_f_valid got=%b exp=1", f_valid); end
    n_vec++; if (ld_words !== 9'd1) begin n_err++; $display("FAIL basic_ld_words got=%0d exp=1", ld_words); end
    tick();
    n_vec++; if (f_valid !== 1'b0 || inst !== 32'h3C1D0020) begin n_err++; $display("FAIL basic_hold got=%b/%h exp=0/3c1d0020", f_valid, inst); end
  endtask

  task automatic test_partial_word();
    start_load();
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    finish_load();
    n_vec++; if (ld_words !== 9'd2) begin n_err++; $display("FAIL partial_ld_words got=%0d exp=2", ld_words); end
    fetch(32'h0);
    n_vec++; if (inst !== 32'h04030201) begin n_err++; $display("FAIL partial_mem0 got=%h exp=04030201", inst); end
    fetch(32'h4);
    n_vec++; if (inst !== 32'h00000605) begin n_err++; $display("FAIL partial_mem1 got=%h exp=00000605", inst); end
    fetch(32'h404);
    n_vec++; if (inst !== 32'h00000605) begin n_err++; $display("FAIL alias_mem1 got=%h exp=00000605", inst); end
  endtask

  task automatic test_byte_with_done();
    start_load();
    send_byte(8'hAA); send_byte(8'hBB);
    ld_valid = 1'b1; ld_byte = 8'hCC; ld_done = 1'b1;
    tick();
    ld_valid = 1'b0; ld_done = 1'b0;
    n_vec++; if (ld_words !== 9'd1 || f_ready !== 1'b1) begin n_err++; $display("FAIL done_byte_words got=%0d/%b exp=1/1", ld_words, f_ready); end
    fetch(32'h0);
    n_vec++; if (inst !== 32'h00CCBBAA) begin n_err++; $display("FAIL done_byte_mem0 got=%h exp=00ccbbaa", inst); end
  endtask

  task automatic test_load_mode();
    start_load();
    fetch(32'h4);
    n_vec++; if (f_valid !== 1'b0 || f_ready !== 1'b0) begin n_err++; $display("FAIL load_fetch got=%b/%b exp=0/0", f_valid, f_ready); end
    n_vec++; if (inst !== 32'h00CCBBAA) begin n_err++; $display("FAIL load_inst_hold got=%h exp=00ccbbaa", inst); end
    for (int i = 0; i < 4; i++) send_byte(8'h77);
    n_vec++; if (ld_words !== 9'd1) begin n_err++; $display("FAIL load_words_pre got=%0d exp=1", ld_words); end
    ld_start = 1'b1; ld_done = 1'b1;
    tick();
    ld_start = 1'b0; ld_done = 1'b0;
    n_vec++; if (ld_ready !== 1'b1 || ld_words !== 9'd0) begin n_err++; $display("FAIL start_over_done got=%b/%0d exp=1/0", ld_ready, ld_words); end
    finish_load();
    n_vec++; if (f_ready !== 1'b1 || ld_words !== 9'd0) begin n_err++; $display("FAIL empty_done got=%b/%0d exp=1/0", f_ready, ld_words); end
    finish_load();
    n_vec++; if (f_ready !== 1'b1 || ld_ready !== 1'b0) begin n_err++; $display("FAIL done_in_run got=%b%b exp=10", f_ready, ld_ready); end
  endtask

  task automatic test_overflow();
    start_load();
    for (int k = 1; k <= 5; k++) begin
      for (int j = 0; j < 4; j++) send_byte(8'(k));
      if (k == 3) begin
        n_vec++; if (s_ld_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early got=%b exp=0", s_ld_ovf); end
      end
      if (k == 4) begin
        n_vec++; if (s_ld_ovf !== 1'b1 || s_ld_words !== 3'd4) begin n_err++; $display("FAIL ovf_wrap got=%b/%0d exp=1/4", s_ld_ovf, s_ld_words); end
      end
    end
    finish_load();
    n_vec++; if (s_ld_ovf !== 1'b1 || s_ld_words !== 3'd4) begin n_err++; $display("FAIL ovf_sat got=%b/%0d exp=1/4", s_ld_ovf, s_ld_words); end
    n_vec++; if (ld_ovf !== 1'b0 || ld_words !== 9'd5) begin n_err++; $display("FAIL big_no_ovf got=%b/%0d exp=0/5", ld_ovf, ld_words); end
    fetch(32'h0);
    n_vec++; if (s_inst !== 32'h05050505) begin n_err++; $display("FAIL ovf_mem0 got=%h exp=05050505", s_inst); end
    n_vec++; if (inst !== 32'h01010101) begin n_err++; $display("FAIL big_mem0 got=%h exp=01010101", inst); end
  endtask

  task automatic test_misalign();
    fetch(32'h6);
`ifdef SCINSTMEM_MISALIGN_TRAP_EN
    n_vec++; if (inst !== 32'h0 || fault !== 1'b1) begin n_err++; $display("FAIL misalign got=%h/%b exp=00000000/1", inst, fault); end
`else
    n_vec++; if (inst !== 32'h02020202 || fault !== 1'b0) begin n_err++; $display("FAIL misalign got=%h/%b exp=02020202/0", inst, fault); end
`endif
    n_vec++; if (f_valid !== 1'b1) begin n_err++; $display("FAIL misalign_valid got=%b exp=1", f_valid); end
    tick();
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL fault_pulse got=%b exp=0", fault); end
  endtask

  task automatic test_reset_mid_load();
    start_load();
    for (int j = 0; j < 4; j++) send_byte(8'h11);
    send_byte(8'h99); send_byte(8'h98);
    n_vec++; if (ld_words !== 9'd1) begin n_err++; $display("FAIL mid_words_pre got=%0d exp=1", ld_words); end
    clrn = 1'b0;
    #1;
    n_vec++; if (f_ready !== 1'b1 || f_valid !== 1'b0 || ld_words !== 9'd0) begin n_err++; $display("FAIL mid_reset got=%b/%b/%0d exp=1/0/0", f_ready, f_valid, ld_words); end
    @(negedge clk);
    clrn = 1'b1;
    tick();
    fetch(32'h0);
    n_vec++; if (inst !== 32'h11111111) begin n_err++; $display("FAIL mid_mem0 got=%h exp=11111111", inst); end
    fetch(32'h4);
    n_vec++; if (inst !== 32'h02020202) begin n_err++; $display("FAIL mid_mem1 got=%h exp=02020202", inst); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_partial_word();
    test_byte_with_done();
    test_load_mode();
    test_overflow();
    test_misalign();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/scinstmem_loader.md
SCINSTMEM_LOADER -- requirements
Module: scinstmem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving word-address bits (depth = 2^ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 32, giving instruction width (multiple of 8).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port f_req  input  1  fetch request.
REQ-006 SHALL have port a  input  32  fetch byte address.
REQ-007 SHALL have port f_ready  output  1  fetch port accepting.
REQ-008 SHALL have port inst  output  DATA_W  fetched instruction.
REQ-009 SHALL have port f_valid  output  1  inst valid, one-cycle pulse.
REQ-010 SHALL have port ld_start  input  1  enter/restart load mode.
REQ-011 SHALL have port ld_byte  input  8  load data byte.
REQ-012 SHALL have port ld_valid  input  1  ld_byte present.
REQ-013 SHALL have port ld_ready  output  1  loader accepting bytes.
REQ-014 SHALL have port ld_done  input  1  end of image.
REQ-015 SHALL have port ld_words  output  ADDR_W+1  words written in current/last load.
REQ-016 SHALL have port ld_ovf  output  1  sticky wrap flag.
REQ-017 SHALL have port fault  output  1  fetch fault (see Configuration).

Function
REQ-018 SHALL implement FSM with states RUN and LOAD.
REQ-019 SHALL, in RUN, drive f_ready=1 and ld_ready=0; in LOAD, f_ready=0 and ld_ready=1.
REQ-020 SHALL, on f_req&f_ready at edge N, present mem[a[ADDR_W+1:2]] on inst with f_valid=1 after edge N+1 (latency 1); upper address bits alias.
REQ-021 SHALL hold inst at last value and f_valid=0 when no fetch accepted; f_req while f_ready=0 is ignored, not queued.
REQ-022 SHALL, on ld_start in any state, go to LOAD, clear write pointer, byte counter, ld_words, ld_ovf, discard any partial word.
REQ-023 SHALL accept a byte on ld_valid&ld_ready, packing little-endian (first byte -> bits 7:0).
REQ-024 SHALL write the word at the write pointer on the edge accepting its DATA_W/8-th byte, then increment pointer and ld_words.
REQ-025 SHALL, when pointer increments from 2^ADDR_W-1, wrap to 0 and set ld_ovf; ld_words saturates at 2^ADDR_W.
REQ-026 SHALL, on ld_done in LOAD, zero-pad and write any partial word (counted in ld_words), then return to RUN next cycle.
REQ-027 SHALL, when ld_valid and ld_done coincide, accept the byte first, then flush as REQ-026.
REQ-028 SHALL give ld_start priority over ld_done in the same cycle; ld_done in RUN is ignored.

Reset
REQ-029 SHALL, on clrn low, immediately enter RUN; inst=0, f_valid=0, fault=0, ld_words=0, ld_ovf=0, pointers=0.
REQ-030 SHALL NOT clear memory contents; reset mid-load abandons the partial word, already-written words persist.

Configuration
REQ-031 SHALL support macro SCINSTMEM_MISALIGN_TRAP_EN.
REQ-032 SHALL, with it defined, return inst=0 and fault=1 (one cycle, with f_valid) for an accepted fetch with a[1:0]!=0.
REQ-033 SHALL, without it, ignore a[1:0] and hold fault=0 permanently.

Verification
REQ-034 Reset, ld_start, bytes 20,00,1D,3C, ld_done, fetch a=0 -> next cycle inst=32'h3C1D0020, f_valid=1, ld_words=1.
REQ-035 Load 6 bytes 01..06 then ld_done -> mem[0]=32'h04030201, mem[1]=32'h00000605, ld_words=2.
REQ-036 ADDR_W=2, load 5 full words -> ld_ovf=1, mem[0] holds word 5, ld_words=4.
REQ-037 f_req in LOAD -> f_ready=0, no f_valid; ld_start and ld_done same cycle -> remains LOAD, counters cleared.
REQ-038 With SCINSTMEM_MISALIGN_TRAP_EN, fetch a=32'h6 -> inst=0, fault=1; without it -> inst=mem[1], fault=0.
REQ-039 clrn low mid-load after 2 bytes -> RUN, f_valid=0, ld_words=0, previously written words readable.
